bullet_pool: RTL and testbench

//  Multi-slot projectile manager; parametrised successor to the single-bullet logic inside the ship block.

---
 rtl/bullet_pool.sv | 149 ++++++++++++++
 tb/tb_bullet_pool.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/bullet_pool.sv
// Multi-slot projectile manager: spawns bullets from the ship under a fire cooldown,
// moves them upward once per frame, retires them off-screen or on hit, and renders a pixel mask.
module bullet_pool #(
    parameter int N_BULLETS = 4,
    parameter int B_W       = 4,
    parameter int B_H       = 8,
    parameter int SPEED     = 4,
    parameter int COOLDOWN  = 8,
    parameter int COORD_W   = 12
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_ani_stb,
    input  logic                 i_animate,
    input  logic                 i_fire,
    input  logic [COORD_W-1:0]   i_ship_x,
    input  logic [COORD_W-1:0]   i_ship_y,
    input  logic [9:0]           i_x,
    input  logic [8:0]           i_y,
    input  logic                 i_hit_valid,
    input  logic [3:0]           i_hit_idx,
    output logic                 o_pixel,
    output logic [3:0]           o_pixel_idx,
    output logic [N_BULLETS-1:0] o_active,
    output logic [4:0]           o_count,
    output logic                 o_fire_ack
);

    localparam int WIDE  = COORD_W + 1;
    localparam int CNT_W = (COOLDOWN > 1) ? $clog2(COOLDOWN + 1) : 1;

    localparam logic [COORD_W-1:0] HALF_W  = COORD_W'(B_W / 2);
    localparam logic [COORD_W-1:0] SPEED_C = COORD_W'(SPEED);
    localparam logic [COORD_W-1:0] B_H_C   = COORD_W'(B_H);
    localparam logic [WIDE-1:0]    B_W_W   = WIDE'(B_W);
    localparam logic [WIDE-1:0]    B_H_W   = WIDE'(B_H);
    localparam logic [CNT_W-1:0]   CD_C    = CNT_W'(COOLDOWN);
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

    logic [N_BULLETS-1:0] active_q, active_d;
    logic [COORD_W-1:0]   x_q [N_BULLETS];
    logic [COORD_W-1:0]   x_d [N_BULLETS];
    logic [COORD_W-1:0]   y_q [N_BULLETS];
    logic [COORD_W-1:0]   y_d [N_BULLETS];
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [4:0]           count_q, count_d;
    logic                 fire_ack_q, fire_ack_d;
    logic                 pixel_q, pixel_d;
    logic [3:0]           pixel_idx_q, pixel_idx_d;

    logic                 tick;
    logic                 can_fire;
    logic                 spawned;
    logic [N_BULLETS-1:0] kill;
    logic [WIDE-1:0]      px, py;

    // Slot update: move/retire, then kills, then spawn into the lowest free non-killed slot.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latches are inferred.
        tick     = i_ani_stb & i_animate;
        active_d = active_q;
        x_d      = x_q;
        y_d      = y_q;
        cnt_d    = cnt_q;
        kill     = '0;
        spawned  = 1'b0;
        count_d  = '0;
        can_fire = tick && i_fire && (cnt_q == '0) && (i_ship_y >= B_H_C);

        for (int i = 0; i < N_BULLETS; i++) begin
            if (tick && active_q[i]) begin
                if (y_q[i] >= SPEED_C) y_d[i] = y_q[i] - SPEED_C;
                else                   active_d[i] = 1'b0;
            end
            if (i_hit_valid && (i_hit_idx == 4'(i))) begin
                kill[i]     = 1'b1;
                active_d[i] = 1'b0;
            end
        end

        for (int i = 0; i < N_BULLETS; i++) begin
            if (can_fire && !spawned && !active_d[i] && !kill[i]) begin
                spawned     = 1'b1;
                active_d[i] = 1'b1;
                x_d[i]      = (i_ship_x < HALF_W) ? '0 : i_ship_x - HALF_W;
                y_d[i]      = i_ship_y - B_H_C;
            end
        end

        // The cooldown test above uses the pre-decrement count.
        if (spawned)                     cnt_d = CD_C;
        else if (tick && cnt_q != '0)    cnt_d = cnt_q - CNT_ONE;

        fire_ack_d = spawned;

        for (int i = 0; i < N_BULLETS; i++) begin
            count_d = count_d + 5'(active_d[i]);
        end
    end

    // Pixel mask: widened compares keep x1+B_W / y1+B_H from wrapping; lowest slot wins.
    always_comb begin
        px          = WIDE'(i_x);
        py          = WIDE'(i_y);
        pixel_d     = 1'b0;
        pixel_idx_d = '0;
        for (int i = N_BULLETS - 1; i >= 0; i--) begin
            if (active_q[i] &&
                ({1'b0, x_q[i]} <= px) && (px < {1'b0, x_q[i]} + B_W_W) &&
                ({1'b0, y_q[i]} <= py) && (py < {1'b0, y_q[i]} + B_H_W)) begin
                pixel_d     = 1'b1;
                pixel_idx_d = 4'(i);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            active_q    <= '0;
            // NOTE: the coordinate arrays are a handful of registers, so they are reset like any flop.
            for (int i = 0; i < N_BULLETS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
            cnt_q       <= '0;
            count_q     <= '0;
            fire_ack_q  <= 1'b0;
            pixel_q     <= 1'b0;
            pixel_idx_q <= '0;
        end else begin
            active_q    <= active_d;
            x_q         <= x_d;
            y_q         <= y_d;
            cnt_q       <= cnt_d;
            count_q     <= count_d;
            fire_ack_q  <= fire_ack_d;
            pixel_q     <= pixel_d;
            pixel_idx_q <= pixel_idx_d;
        end
    end

    assign o_active    = active_q;
    assign o_count     = count_q;
    assign o_fire_ack  = fire_ack_q;
    assign o_pixel     = pixel_q;
    assign o_pixel_idx = pixel_idx_q;

endmodule

// File: tb/tb_bullet_pool.sv
// Self-checking bench for bullet_pool: table-driven tick/hit vectors through a scoreboard
// queue, plus pixel probes, on a default instance and a zero-cooldown instance.
module tb_bullet_pool;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ani_stb, animate, fire, hit_valid;
    logic [11:0] ship_x, ship_y;
    logic [9:0]  px;
    logic [8:0]  py;
    logic [3:0]  hit_idx;

    logic        pix_a, pix_b, ack_a, ack_b;
    logic [3:0]  pidx_a, pidx_b, act_a, act_b;
    logic [4:0]  cnt_a, cnt_b;

    bit use0;
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bullet_pool u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ani_stb(ani_stb), .i_animate(animate),
        .i_fire(fire), .i_ship_x(ship_x), .i_ship_y(ship_y), .i_x(px), .i_y(py),
        .i_hit_valid(hit_valid), .i_hit_idx(hit_idx),
        .o_pixel(pix_a), .o_pixel_idx(pidx_a), .o_active(act_a), .o_count(cnt_a),
        .o_fire_ack(ack_a)
    );

    bullet_pool #(.COOLDOWN(0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_ani_stb(ani_stb), .i_animate(animate),
        .i_fire(fire), .i_ship_x(ship_x), .i_ship_y(ship_y), .i_x(px), .i_y(py),
        .i_hit_valid(hit_valid), .i_hit_idx(hit_idx),
        .o_pixel(pix_b), .o_pixel_idx(pidx_b), .o_active(act_b), .o_count(cnt_b),
        .o_fire_ack(ack_b)
    );

    typedef struct {
        bit stb; bit ani; bit fire; int sx; int sy; bit hv; int hi;
        bit e_ack; int e_cnt; int e_act;
    } vec_t;

    typedef struct {
        int x; int y; bit e_pix; int e_idx;
    } pix_t;

    vec_t exp_q[$];
    pix_t pix_q[$];

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input bit stb, input bit ani, input bit f, input int sx,
                                input int sy, input bit hv, input int hi,
                                input bit e_ack, input int e_cnt, input int e_act);
        vec_t v;
        v.stb = stb; v.ani = ani; v.fire = f; v.sx = sx; v.sy = sy; v.hv = hv; v.hi = hi;
        v.e_ack = e_ack; v.e_cnt = e_cnt; v.e_act = e_act;
        return v;
    endfunction

    task automatic step(input vec_t v, input string tag);
        vec_t e;
        @(negedge clk);
        ani_stb   = v.stb;
        animate   = v.ani;
        fire      = v.fire;
        ship_x    = 12'(v.sx);
        ship_y    = 12'(v.sy);
        hit_valid = v.hv;
        hit_idx   = 4'(v.hi);
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        ani_stb   = 1'b0;
        animate   = 1'b0;
        hit_valid = 1'b0;
        e = exp_q.pop_front();
        check({tag, " ack"},    int'(use0 ? ack_b : ack_a), int'(e.e_ack));
        check({tag, " count"},  int'(use0 ? cnt_b : cnt_a), e.e_cnt);
        check({tag, " active"}, int'(use0 ? act_b : act_a), e.e_act);
    endtask

    task automatic run_table(input vec_t t[$], input string pfx);
        for (int i = 0; i < t.size(); i++) step(t[i], $sformatf("%s%0d", pfx, i));
    endtask

    task automatic probe(input int x, input int y, input bit e_pix, input int e_idx);
        pix_t p;
        pix_t e;
        @(negedge clk);
        px = 10'(x);
        py = 9'(y);
        p.x = x; p.y = y; p.e_pix = e_pix; p.e_idx = e_idx;
        pix_q.push_back(p);
        @(posedge clk);
        #1;
        e = pix_q.pop_front();
        check($sformatf("pix(%0d,%0d)", e.x, e.y), int'(use0 ? pix_b : pix_a), int'(e.e_pix));
        check($sformatf("idx(%0d,%0d)", e.x, e.y), int'(use0 ? pidx_b : pidx_a), e.e_idx);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " pix_a"},  int'(pix_a),  0);
        check({tag, " pidx_a"}, int'(pidx_a), 0);
        check({tag, " act_a"},  int'(act_a),  0);
        check({tag, " cnt_a"},  int'(cnt_a),  0);
        check({tag, " ack_a"},  int'(ack_a),  0);
        check({tag, " act_b"},  int'(act_b),  0);
        check({tag, " cnt_b"},  int'(cnt_b),  0);
        check({tag, " ack_b"},  int'(ack_b),  0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t q_a0[$];
        vec_t q_a1[$];
        vec_t q_a2[$];
        vec_t q_b0[$];
        vec_t q_b1[$];
        vec_t q_b2[$];

        // Default instance (COOLDOWN=8): first spawn, strobe qualification, cooldown of 9 ticks.
        q_a0.push_back(mk(1, 1, 1, 320, 400, 0, 0, 1, 1, 1));
        q_a0.push_back(mk(1, 0, 1, 320, 400, 0, 0, 0, 1, 1));
        q_a0.push_back(mk(0, 1, 1, 320, 400, 0, 0, 0, 1, 1));
        for (int i = 0; i < 8; i++) q_a1.push_back(mk(1, 1, 1, 320, 400, 0, 0, 0, 1, 1));
        q_a1.push_back(mk(1, 1, 1, 320, 400, 0, 0, 1, 2, 3));
        // Drain cooldown, then hit slot1 on a ready tick: spawn goes to slot2.
        for (int i = 0; i < 8; i++) q_a2.push_back(mk(1, 1, 0, 320, 400, 0, 0, 0, 2, 3));
        q_a2.push_back(mk(1, 1, 1, 320, 400, 1, 1, 1, 2, 5));
        q_a2.push_back(mk(0, 0, 0, 320, 400, 1, 5, 0, 2, 5));
        q_a2.push_back(mk(0, 0, 0, 320, 400, 1, 0, 0, 1, 4));
        q_a2.push_back(mk(0, 0, 0, 320, 400, 1, 3, 0, 1, 4));

        // Zero-cooldown instance: fill, retire-and-reuse, full pool, guards, kill vs spawn.
        q_b0.push_back(mk(1, 1, 1, 320, 400, 0, 0, 1, 1, 1));
        q_b0.push_back(mk(1, 1, 1, 320, 400, 0, 0, 1, 2, 3));
        q_b1.push_back(mk(1, 1, 1, 320, 400, 0, 0, 1, 3, 7));
        q_b1.push_back(mk(1, 1, 1, 320, 11,  0, 0, 1, 4, 15));
        q_b1.push_back(mk(1, 1, 1, 320, 400, 0, 0, 1, 4, 15));
        q_b2.push_back(mk(1, 1, 1, 320, 400, 0, 0, 0, 4, 15));
        q_b2.push_back(mk(1, 1, 0, 320, 400, 1, 2, 0, 3, 11));
        q_b2.push_back(mk(1, 1, 1, 320, 7,   0, 0, 0, 3, 11));
        q_b2.push_back(mk(1, 1, 1, 1,   8,   0, 0, 1, 4, 15));

        rst_n = 1'b0; ani_stb = 1'b0; animate = 1'b0; fire = 1'b0;
        ship_x = '0; ship_y = '0; px = '0; py = '0; hit_valid = 1'b0; hit_idx = '0;
        use0 = 1'b0;

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        run_table(q_a0, "a0_");
        for (int y = 390; y <= 401; y++) begin
            for (int x = 316; x <= 323; x++) begin
                probe(x, y, (x >= 318 && x <= 321 && y >= 392 && y <= 399), 0);
            end
        end
        run_table(q_a1, "a1_");
        probe(318, 356, 1, 0);
        probe(318, 355, 0, 0);
        probe(321, 363, 1, 0);
        probe(322, 363, 0, 0);
        probe(318, 392, 1, 1);
        run_table(q_a2, "a2_");

        // Reset asserted mid-frame with live bullets.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        use0 = 1'b1;
        run_table(q_b0, "b0_");
        probe(319, 393, 1, 0);
        probe(319, 390, 1, 0);
        probe(319, 398, 1, 1);
        probe(319, 400, 0, 0);
        run_table(q_b1, "b1_");
        probe(319, 392, 1, 3);
        probe(319, 391, 1, 2);
        run_table(q_b2, "b2_");
        probe(0, 0, 1, 2);
        probe(3, 7, 1, 2);
        probe(4, 0, 0, 0);
        probe(0, 8, 0, 0);

        // Multi-cycle corners: y1=0 retires; kill and spawn on one tick; invalid hit index.
        step(mk(1, 1, 0, 320, 400, 0, 0, 0, 3, 11), "c_retire0");
        step(mk(1, 1, 1, 320, 400, 1, 0, 1, 3, 14), "c_killspawn");
        step(mk(0, 0, 0, 320, 400, 1, 15, 0, 3, 14), "c_badidx");
        step(mk(0, 0, 0, 320, 400, 0, 0, 0, 3, 14), "c_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
